// File: rtl/dma_copy.sv
// dma_copy: word-granular copy engine that shares the data-cache request port
// with the CPU through a request/grant arbiter. It moves word_count 32-bit
// words from src_addr to dst_addr one read/write pair at a time, following the
// responder's clk_stall handshake (rise, then fall) for every access.
// Build option: define DMA_FILL_EN to add fill_mode/fill_value (memory fill,
// no reads, source address ignored).
module dma_copy #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [3:0]  WORD_MASK = 4'b0111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [3:0]       mem_sign_mask,
    input  logic [31:0]      mem_read_data,
    input  logic             mem_clk_stall
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdWaitHi,
        StRdWaitLo,
        StWrIssue,
        StWrWaitHi,
        StWrWaitLo,
        StFinish
    } state_e;

    state_e           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      data_q;
    logic             fill_q;
    logic             bad_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    logic             start_fill;
    logic             start_bad;
    logic [31:0]      start_data;
    logic             rd_stb;
    logic             wr_stb;

    // Reset asserts asynchronously, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Decode the request presented with start (fill selection, alignment).
    always_comb begin
`ifdef DMA_FILL_EN
        start_fill = fill_mode;
        start_data = fill_value;
`else
        start_fill = 1'b0;
        start_data = 32'h0;
`endif
        // A fill never reads, so its source address is not checked.
        start_bad = (dst_addr[1:0] != 2'b00) || (!start_fill && (src_addr[1:0] != 2'b00));
    end

    // Transfer FSM with its datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            cnt_q   <= '0;
            data_q  <= 32'h0;
            fill_q  <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        cnt_q  <= word_count;
                        data_q <= start_data;
                        fill_q <= start_fill;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        bad_q  <= start_bad;
                        if (start_bad || (word_count == '0)) begin
                            state_q <= StFinish;
                        end else if (start_fill) begin
                            state_q <= StWrIssue;
                        end else begin
                            state_q <= StRdIssue;
                        end
                    end
                end
                StRdIssue: begin
                    if (bus_gnt) state_q <= StRdWaitHi;
                end
                StRdWaitHi: begin
                    if (mem_clk_stall) state_q <= StRdWaitLo;
                end
                StRdWaitLo: begin
                    if (!mem_clk_stall) begin
                        data_q  <= mem_read_data;
                        src_q   <= src_q + 32'd4;
                        state_q <= StWrIssue;
                    end
                end
                StWrIssue: begin
                    if (bus_gnt) state_q <= StWrWaitHi;
                end
                StWrWaitHi: begin
                    if (mem_clk_stall) state_q <= StWrWaitLo;
                end
                StWrWaitLo: begin
                    if (!mem_clk_stall) begin
                        dst_q <= dst_q + 32'd4;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= StFinish;
                        end else if (fill_q) begin
                            state_q <= StWrIssue;
                        end else begin
                            state_q <= StRdIssue;
                        end
                    end
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    err_q   <= bad_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bus outputs: strobes only in a granted ISSUE cycle, so each is one cycle wide.
    always_comb begin
        rd_stb         = (state_q == StRdIssue) && bus_gnt;
        wr_stb         = (state_q == StWrIssue) && bus_gnt;
        bus_req        = (state_q != StIdle) && (state_q != StFinish);
        mem_memread    = rd_stb;
        mem_memwrite   = wr_stb;
        mem_sign_mask  = (rd_stb || wr_stb) ? WORD_MASK : 4'b0000;
        mem_write_data = wr_stb ? data_q : 32'h0;
        if (rd_stb) begin
            mem_addr = src_q;
        end else if (wr_stb) begin
            mem_addr = dst_q;
        end else begin
            mem_addr = 32'h0;
        end
        busy = busy_q;
        done = done_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: stimulus pushes expected accesses and done
// events, a negedge monitor pops and compares them against the bus.
module tb_dma_copy;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        fill_mode;
    logic [31:0] fill_value;
    logic        busy, done, err, bus_req;
    logic        bus_gnt;
    logic [31:0] mem_addr, mem_write_data;
    logic        mem_memread, mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_clk_stall = 1'b0;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          done_seen = 0;
    int          stall_cnt = 0;
    logic        gnt_test = 1'b0;
    logic        prev_stb = 1'b0;
    logic        stb;
    acc_t        exp_acc[$];
    done_t       exp_done[$];
    acc_t        a;
    done_t       d;

    dma_copy dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .word_count     (word_count),
`ifdef DMA_FILL_EN
        .fill_mode      (fill_mode),
        .fill_value     (fill_value),
`endif
        .busy           (busy),
        .done           (done),
        .err            (err),
        .bus_req        (bus_req),
        .bus_gnt        (bus_gnt),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents seen by reads: a fixed function of the address.
    function automatic logic [31:0] rd_model(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]} ^ 32'h0F0F_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Responder: stall rises one cycle after a strobe and stays high 2 cycles.
    always @(posedge clk) begin
        if (mem_memread || mem_memwrite) begin
            stall_cnt     <= 2;
            mem_clk_stall <= 1'b1;
            if (mem_memread) mem_read_data <= rd_model(mem_addr);
        end else if (stall_cnt > 1) begin
            stall_cnt <= stall_cnt - 1;
        end else begin
            stall_cnt     <= 0;
            mem_clk_stall <= 1'b0;
        end
    end

    // Grant: tied high, except low for cycles 1-3 and 8-10 after start in the grant test.
    always @(posedge clk) begin
        #2;
        bus_gnt = !(gnt_test && ((cyc - t0) inside {1, 2, 3, 8, 9, 10}));
    end

    // Monitor: compare every strobe and every done pulse with the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            stb = mem_memread || mem_memwrite;
            if (stb) begin
                check("strobe_gnt", {31'b0, bus_gnt}, 32'd1);
                check("strobe_width", {31'b0, prev_stb}, 32'd0);
                check("strobe_req", {31'b0, bus_req}, 32'd1);
                check("sign_mask", {28'b0, mem_sign_mask}, 32'h7);
                if (exp_acc.size() == 0) begin
                    fail_now("acc_unexpected");
                end else begin
                    a = exp_acc.pop_front();
                    check("acc_kind", {31'b0, mem_memwrite}, {31'b0, a.wr});
                    check("acc_addr", mem_addr, a.addr);
                    if (a.wr) check("acc_wdata", mem_write_data, a.data);
                end
            end
            prev_stb = stb;
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    d = exp_done.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_err", {31'b0, err}, {31'b0, d.err});
                    check("done_busy", {31'b0, busy}, 32'd0);
                end
            end
        end else begin
            prev_stb = 1'b0;
        end
    end

    task automatic push_acc(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        acc_t e;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        exp_acc.push_back(e);
    endtask

    // Pulse start for one cycle; done is expected done_off cycles later.
    task automatic launch(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt,
                          input logic fill, input logic [31:0] fv, input int done_off,
                          input logic exp_err, input logic want_done);
        done_t e;
        @(posedge clk);
        #1;
        src_addr   = src;
        dst_addr   = dst;
        word_count = cnt;
        fill_mode  = fill;
        fill_value = fv;
        start      = 1'b1;
        t0         = cyc;
        if (want_done) begin
            e.cyc = t0 + done_off;
            e.err = exp_err;
            exp_done.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_acc.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_acc.size() + exp_done.size(), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int seen;
        rst_n      = 1'b1;
        start      = 1'b0;
        src_addr   = 32'h0;
        dst_addr   = 32'h0;
        word_count = 16'd0;
        fill_mode  = 1'b0;
        fill_value = 32'h0;
        bus_gnt    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {26'b0, busy, done, err, bus_req, mem_memread, mem_memwrite}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_mask", {28'b0, mem_sign_mask}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // 4-word copy 0x1000 -> 0x1100, grant high: done at 8*4+2.
        for (int i = 0; i < 4; i++) begin
            push_acc(1'b0, 32'h1000 + 32'(4 * i), 32'h0);
            push_acc(1'b1, 32'h1100 + 32'(4 * i), rd_model(32'h1000 + 32'(4 * i)));
        end
        launch(32'h1000, 32'h1100, 16'd4, 1'b0, 32'h0, 34, 1'b0, 1'b1);
        drain(100);

        // Zero-length transfer: no access, done 2 cycles after start.
        launch(32'h1000, 32'h1100, 16'd0, 1'b0, 32'h0, 2, 1'b0, 1'b1);
        drain(20);

        // Misaligned source: err with done, no access; err holds afterwards.
        launch(32'h1002, 32'h1100, 16'd3, 1'b0, 32'h0, 2, 1'b1, 1'b1);
        drain(20);
        check("err_held", {31'b0, err}, 32'd1);

        // 1-word copy with grant withheld 3 cycles per issue: done at 10+6.
        gnt_test = 1'b1;
        push_acc(1'b0, 32'h0000_0400, 32'h0);
        push_acc(1'b1, 32'h0000_0800, rd_model(32'h0000_0400));
        launch(32'h0000_0400, 32'h0000_0800, 16'd1, 1'b0, 32'h0, 16, 1'b0, 1'b1);
        drain(60);
        gnt_test = 1'b0;

        // Second start mid-transfer is dropped; reset in WR_WAIT_HI aborts silently.
        push_acc(1'b0, 32'h2000, 32'h0);
        push_acc(1'b1, 32'h2100, rd_model(32'h2000));
        launch(32'h2000, 32'h2100, 16'd1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        src_addr   = 32'h3000;
        dst_addr   = 32'h3100;
        word_count = 16'd5;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < t0 + 6) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_req", {31'b0, bus_req}, 32'd1);
        seen  = done_seen;
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", {26'b0, busy, done, err, bus_req, mem_memread, mem_memwrite}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_wdata", mem_write_data, 32'd0);
        check("abort_mask", {28'b0, mem_sign_mask}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", done_seen, seen);
        check("abort_idle", {30'b0, busy, bus_req}, 32'd0);
        drain(5);

`ifdef DMA_FILL_EN
        // Fill 3 words of 0xDEADBEEF at 0x1200; unaligned src is ignored: done at 4*3+2.
        for (int i = 0; i < 3; i++) push_acc(1'b1, 32'h1200 + 32'(4 * i), 32'hDEAD_BEEF);
        launch(32'h0000_1003, 32'h1200, 16'd3, 1'b1, 32'hDEAD_BEEF, 14, 1'b0, 1'b1);
        drain(60);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
